// File: rtl/noc_flit_pkg.sv
// Flit format and mesh constants shared by the injector and the router route-compute stage.
package noc_flit_pkg;

    localparam int FLIT_W   = 8;
    localparam int MESH_X   = 4;
    localparam int MESH_Y   = 4;
    localparam int NODE_X_W = 2;
    localparam int NODE_Y_W = 2;
    localparam int LEN_W    = 2;
    localparam int PAY_W    = 6;

    localparam int TYPE_MSB = 7;
    localparam int TYPE_LSB = 6;
    localparam int LEN_MSB  = 5;
    localparam int LEN_LSB  = 4;
    localparam int DY_MSB   = 3;
    localparam int DY_LSB   = 2;
    localparam int DX_MSB   = 1;
    localparam int DX_LSB   = 0;

    typedef enum logic [1:0] {
        FT_BODY = 2'b00,
        FT_TAIL = 2'b01,
        FT_HEAD = 2'b10
    } flit_type_e;

    function automatic logic [FLIT_W-1:0] mk_head(
        input logic [LEN_W-1:0]    len,
        input logic [NODE_Y_W-1:0] dy,
        input logic [NODE_X_W-1:0] dx
    );
        return {FT_HEAD, len, dy, dx};
    endfunction

    function automatic logic [FLIT_W-1:0] mk_pay(
        input flit_type_e       t,
        input logic [PAY_W-1:0] d
    );
        return {t, d};
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Saturating credit counter for the router local-port input buffer.
module noc_credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_consume,
    input  logic i_return,
    output logic o_nonzero
);

    localparam logic [3:0] MAX = 4'(CREDITS);

    logic [3:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= MAX;
        end else if (i_consume && !i_return) begin
            r_count <= r_count - 4'd1;
        end else if (!i_consume && i_return && r_count != MAX) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_nonzero = (r_count != 4'd0);

endmodule

// File: rtl/noc_packet_injector.sv
// Packetizes local commands into head/body/tail flits under credit flow control.
// Optional NOC_INJ_PKT_CNT_EN adds a tail-flit packet counter output pkt_cnt.
module noc_packet_injector
    import noc_flit_pkg::*;
#(
    parameter logic [NODE_X_W-1:0] SRC_X   = 2'd1,
    parameter logic [NODE_Y_W-1:0] SRC_Y   = 2'd2,
    parameter int                  CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_dst_x,
    input  logic [1:0]        cmd_dst_y,
    input  logic [1:0]        cmd_len,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [PAY_W-1:0]  data_in,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              credit_in,
    output logic              busy,
    output logic              err_self
`ifdef NOC_INJ_PKT_CNT_EN
    ,
    output logic [15:0]       pkt_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_DATA
    } state_e;

    state_e              r_state;
    logic [NODE_X_W-1:0] r_dst_x;
    logic [NODE_Y_W-1:0] r_dst_y;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_rem;
    logic [FLIT_W-1:0]   r_flit;
    logic                r_fvalid;
    logic                r_busy;
    logic                r_err;

    logic w_nz;
    logic w_self;
    logic w_head_send;
    logic w_data_send;
    logic w_send;
    logic w_tail;

    assign cmd_ready   = (r_state == S_IDLE);
    assign data_ready  = (r_state == S_DATA) && w_nz;
    assign w_self      = (cmd_dst_x == SRC_X) && (cmd_dst_y == SRC_Y);
    assign w_head_send = (r_state == S_HEAD) && w_nz;
    assign w_data_send = data_valid && data_ready;
    assign w_send      = w_head_send || w_data_send;
    assign w_tail      = w_data_send && (r_rem == '0);

    noc_credit_counter #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_consume (w_send),
        .i_return  (credit_in),
        .o_nonzero (w_nz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_dst_x  <= '0;
            r_dst_y  <= '0;
            r_len    <= '0;
            r_rem    <= '0;
            r_flit   <= '0;
            r_fvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_fvalid <= 1'b0;
            r_err    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // The router has no route for a self-addressed packet
                        if (w_self) begin
                            r_err <= 1'b1;
                        end else begin
                            r_dst_x <= cmd_dst_x;
                            r_dst_y <= cmd_dst_y;
                            r_len   <= cmd_len;
                            r_rem   <= cmd_len;
                            r_busy  <= 1'b1;
                            r_state <= S_HEAD;
                        end
                    end
                end
                S_HEAD: begin
                    if (w_head_send) begin
                        r_flit   <= mk_head(r_len, r_dst_y, r_dst_x);
                        r_fvalid <= 1'b1;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_data_send) begin
                        r_fvalid <= 1'b1;
                        if (w_tail) begin
                            r_flit  <= mk_pay(FT_TAIL, data_in);
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_flit <= mk_pay(FT_BODY, data_in);
                            r_rem  <= r_rem - 2'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef NOC_INJ_PKT_CNT_EN
    logic [15:0] r_pkt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt <= '0;
        end else if (w_tail) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

    assign flit_out   = r_flit;
    assign flit_valid = r_fvalid;
    assign busy       = r_busy;
    assign err_self   = r_err;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Scoreboard bench for noc_packet_injector: directed packets, credit stalls, self-drop, reset.
module tb_noc_packet_injector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_dst_x;
    logic [1:0] cmd_dst_y;
    logic [1:0] cmd_len;
    logic       data_valid;
    logic       data_ready;
    logic [5:0] data_in;
    logic [7:0] flit_out;
    logic       flit_valid;
    logic       credit_in;
    logic       busy;
    logic       err_self;
`ifdef NOC_INJ_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    noc_packet_injector #(
        .SRC_X   (2'd1),
        .SRC_Y   (2'd2),
        .CREDITS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dst_x  (cmd_dst_x),
        .cmd_dst_y  (cmd_dst_y),
        .cmd_len    (cmd_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_in    (data_in),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .credit_in  (credit_in),
        .busy       (busy),
        .err_self   (err_self)
`ifdef NOC_INJ_PKT_CNT_EN
        ,
        .pkt_cnt    (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         n_err  = 0;
    int         cyc    = 0;
    logic [7:0] exp_q[$];
    int         stamp[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every flit the DUT presents is checked against the queue head
    always @(negedge clk) begin
        if (rst_n) begin
            if (flit_valid) begin
                stamp.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_flit", {8'h0, flit_out}, 16'hFFFF);
                end else begin
                    chk("flit", {8'h0, flit_out}, {8'h0, exp_q.pop_front()});
                end
            end
            if (err_self) n_err++;
        end
    end

    task automatic send_cmd(input logic [1:0] x, input logic [1:0] y, input logic [1:0] l);
        bit ok = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dst_x = x;
        cmd_dst_y = y;
        cmd_len   = l;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("cmd_accept");
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [5:0] w);
        bit ok = 0;
        data_valid = 1'b1;
        data_in    = w;
        for (int i = 0; i < 50; i++) begin
            if (data_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) timeout("data_accept");
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic wait_flits(input int n, input string nm);
        for (int i = 0; i < 40; i++) begin
            if (stamp.size() >= n) break;
            @(negedge clk);
            #1;
        end
        chk(nm, 16'(stamp.size()), 16'(n));
    endtask

    task automatic pulse_credit();
        @(negedge clk);
        credit_in = 1'b1;
        @(negedge clk);
        credit_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int e;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_dst_x  = '0;
        cmd_dst_y  = '0;
        cmd_len    = '0;
        data_valid = 1'b0;
        data_in    = '0;
        credit_in  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_flit_valid", {15'h0, flit_valid}, 16'h0);
        chk("rst_flit_out", {8'h0, flit_out}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_err_self", {15'h0, err_self}, 16'h0);
        chk("rst_cmd_ready", {15'h0, cmd_ready}, 16'h1);
        chk("rst_data_ready", {15'h0, data_ready}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic packet: dst (3,2), two payload words
        exp_q.push_back(8'h9B);
        exp_q.push_back(8'h15);
        exp_q.push_back(8'h6A);
        send_cmd(2'd3, 2'd2, 2'd1);
        send_word(6'h15);
        send_word(6'h2A);
        wait_flits(3, "t1_count");
        chk("t1_consecutive", 16'(stamp[2] - stamp[0]), 16'd2);

        // Credit returned with every send, starting from one credit
        b = stamp.size();
        exp_q.push_back(8'hAC);
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h49);
        send_cmd(2'd0, 2'd3, 2'd2);
        fork
            begin
                credit_in = 1'b1;
                repeat (4) @(negedge clk);
                credit_in = 1'b0;
            end
            begin
                send_word(6'h07);
                send_word(6'h08);
                send_word(6'h09);
            end
        join
        wait_flits(b + 4, "t4_count");
        chk("t4_no_stall", 16'(stamp[b+3] - stamp[b]), 16'd3);

        // 1 -> 4 plus one extra return that must saturate
        repeat (4) pulse_credit();

        // Four credits, four-payload packet: tail stalls until a credit returns
        b = stamp.size();
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h4C);
        send_cmd(2'd2, 2'd3, 2'd3);
        send_word(6'h11);
        send_word(6'h22);
        send_word(6'h33);
        data_valid = 1'b1;
        data_in    = 6'h0C;
        repeat (5) @(negedge clk);
        #1;
        chk("t3_stall_flits", 16'(stamp.size()), 16'(b + 4));
        chk("t3_stall_ready", {15'h0, data_ready}, 16'h0);
        chk("t3_stall_busy", {15'h0, busy}, 16'h1);
        credit_in = 1'b1;
        @(negedge clk);
        credit_in = 1'b0;
        wait_flits(b + 5, "t3_tail");
        data_valid = 1'b0;
        repeat (4) pulse_credit();

        // Self-addressed command is dropped
        e = n_err;
        b = stamp.size();
        send_cmd(2'd1, 2'd2, 2'd0);
        #1;
        chk("t2_err_pulse", {15'h0, err_self}, 16'h1);
        chk("t2_busy", {15'h0, busy}, 16'h0);
        @(negedge clk);
        #1;
        chk("t2_err_clear", {15'h0, err_self}, 16'h0);
        chk("t2_err_count", 16'(n_err), 16'(e + 1));
        chk("t2_no_flit", 16'(stamp.size()), 16'(b));

        // Data gap mid-packet
        b = stamp.size();
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h43);
        send_cmd(2'd0, 2'd0, 2'd2);
        send_word(6'h01);
        repeat (3) @(negedge clk);
        #1;
        chk("t5_gap_flits", 16'(stamp.size()), 16'(b + 2));
        send_word(6'h02);
        send_word(6'h03);
        wait_flits(b + 4, "t5_count");
        repeat (4) pulse_credit();
`ifdef NOC_INJ_PKT_CNT_EN
        chk("pkt_cnt", pkt_cnt, 16'd4);
`endif

        // Reset right after a header
        send_cmd(2'd2, 2'd1, 2'd2);
        @(posedge clk);
        #1;
        chk("t6_head_valid", {15'h0, flit_valid}, 16'h1);
        chk("t6_head", {8'h0, flit_out}, 16'h00A6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {15'h0, flit_valid}, 16'h0);
        chk("t6_rst_busy", {15'h0, busy}, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_cmd_ready", {15'h0, cmd_ready}, 16'h1);
`ifdef NOC_INJ_PKT_CNT_EN
        chk("pkt_cnt_rst", pkt_cnt, 16'd0);
`endif
        b = stamp.size();
        exp_q.push_back(8'hBF);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0B);
        exp_q.push_back(8'h0C);
        send_cmd(2'd3, 2'd3, 2'd3);
        send_word(6'h0A);
        send_word(6'h0B);
        send_word(6'h0C);
        wait_flits(b + 4, "t6_count");
        data_valid = 1'b1;
        data_in    = 6'h3F;
        repeat (3) @(negedge clk);
        #1;
        chk("t6_credits_spent", {15'h0, data_ready}, 16'h0);
        chk("t6_no_extra", 16'(stamp.size()), 16'(b + 4));
        data_valid = 1'b0;

        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_packet_injector.md
Name: noc_packet_injector

Overview:
Source-side network interface for the 4x4 mesh. It packetizes a local command (destination, length) plus a payload word stream into header/body/tail flits. It injects those flits into the router's local input port under credit-based flow control. Its header flit layout is exactly what the router's route-compute stage decodes: dest_x in bits [1:0], dest_y in bits [3:2].

Parameters:
SRC_X, 1, X coordinate of this node (2 bits)
SRC_Y, 2, Y coordinate of this node (2 bits)
CREDITS, 4, depth of router local-port input buffer; initial and maximum credit count (1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  packet command present
cmd_ready  output  1  injector accepts command this cycle
cmd_dst_x  input  2  destination X
cmd_dst_y  input  2  destination Y
cmd_len  input  2  payload flit count minus 1 (1..4 payload flits)
data_valid  input  1  payload word present
data_ready  output  1  payload word consumed this cycle
data_in  input  6  payload word
flit_out  output  8  flit to router local input
flit_valid  output  1  flit_out valid; one-cycle pulse per flit
credit_in  input  1  one buffer slot freed in router; one-cycle pulse
busy  output  1  packet in progress (state != IDLE)
err_self  output  1  one-cycle pulse: command dropped, destination == own node

Behaviour:
- Flit format: [7:6] type (HEAD=2'b10, BODY=2'b00, TAIL=2'b01); header [5:4]=len, [3:2]=dst_y, [1:0]=dst_x; body/tail [5:0]=payload.
- Reset values: flit_out=0, flit_valid=0, err_self=0, busy=0, state=IDLE, credit_cnt=CREDITS, remaining=0.
- All outputs except cmd_ready/data_ready are registered. cmd_ready = (state==IDLE). data_ready = (state==DATA && credit_cnt!=0).
- FSM IDLE: on cmd_valid&&cmd_ready:
  - if dst==(SRC_X,SRC_Y): err_self=1 next cycle, stay IDLE. The router has no defined route for a self-destination.
  - else: latch dst/len into remaining=len, go HEAD.
- FSM HEAD: if credit_cnt!=0, emit header (flit_valid=1 next cycle), decrement credit, go DATA. Else stall, flit_valid=0.
- FSM DATA: on data_valid&&data_ready, emit {type,data_in} and decrement credit.
  - type=TAIL when remaining==0, then go IDLE.
  - else type=BODY, remaining-=1.
- Latency: command accepted at edge N -> header visible after edge N+1 at the earliest. Back-to-back packets leave one IDLE cycle between a tail and the next header.
- Credits:
  - credit_in increments the count.
  - Send and credit_in in the same cycle: count unchanged.
  - credit_in at credit_cnt==CREDITS: ignored (saturate).
  - No flit is ever emitted with credit_cnt==0.
- Data stall in DATA: no flit, no state change, header not repeated.
- Reset mid-packet: packet abandoned, all state to reset values, credits restored to CREDITS.
- Width rule: destination comparison is unsigned 2-bit equality. The injector performs no routing; it only encodes.

Optional Feature:
NOC_INJ_PKT_CNT_EN:
- Defined: adds output pkt_cnt[15:0], reset 0. It increments on each tail flit emitted and wraps 16'hFFFF -> 0. Dropped self-destination commands are not counted.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package noc_flit_pkg: FLIT_W=8, flit type constants HEAD/BODY/TAIL, field bit positions, X/Y node-number widths, mesh size 4x4. This package is shared with the router route-compute stage.
- One sub-module, noc_credit_counter: saturating up/down counter with consume/return inputs and a nonzero output, parameterized by CREDITS.

Test Plan:
1. Reset, cmd dst=(3,2) len=1, data 6'h15, 6'h2A, ample credits -> flit 8'h9B, then 8'h15 (BODY), then 8'h6A (TAIL), pulses on consecutive cycles; credit_cnt 4->1.
2. cmd dst=(1,2) (self) -> err_self pulse one cycle later, no flit_valid, busy stays 0.
3. CREDITS=4, len=3 (4 payload flits), no credit_in -> header + 3 flits sent, then stall. A credit_in pulse releases the tail one cycle later.
4. credit_in coincident with every send starting at credit_cnt=1 -> flits stream with no stall; count stays 1. Extra credit_in at 4 -> stays 4.
5. data_valid deasserted for 3 cycles mid-packet -> no flit_valid, no duplicated header; stream resumes with correct BODY/TAIL typing.
6. rst_n asserted after header of len=2 packet -> flit_valid=0 immediately. After release, credit_cnt=4, cmd_ready=1, and the next packet starts with a header.
